modul_masini: RTL and testbench

Vehicle-side traffic-light controller that initiates the pedestrian crossing handshake answered by the pedestrian module. It runs the car lamps (green / yellow / red / red+yellow), latches the pedestrian push-button, stops traffic, pulses `Pietoni_start`, and holds cars at red until the pedestrian side returns `Pietoni_stop`. It also provides maintenance mode (blinking yellow) and a watchdog that drops to a sticky fault if the pedestrian side never answers.

---
 rtl/semafoare_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 33 +++
 rtl/modul_masini.sv | 175 +++++++++++++++++
 tb/tb_modul_masini.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/semafoare_pkg.sv
// Shared definitions for the car-side and pedestrian-side traffic-light controllers.
// Contents: 3-bit FSM state encoding, lamp tuple type and constants, default timings,
// and a helper that maps a state to its steady lamp tuple.
package semafoare_pkg;

    // FSM state encoding (shared with the pedestrian module)
    localparam logic [2:0] StInit        = 3'd0;
    localparam logic [2:0] StRosuGalben  = 3'd1;
    localparam logic [2:0] StVerde       = 3'd2;
    localparam logic [2:0] StGalben      = 3'd3;
    localparam logic [2:0] StRosuStart   = 3'd4;
    localparam logic [2:0] StRosuAstept  = 3'd5;
    localparam logic [2:0] StIntretinere = 3'd6;

    typedef struct packed {
        logic rosu;
        logic galben;
        logic verde;
    } lampi_t;

    localparam lampi_t LampiRosu       = '{rosu: 1'b1, galben: 1'b0, verde: 1'b0};
    localparam lampi_t LampiRosuGalben = '{rosu: 1'b1, galben: 1'b1, verde: 1'b0};
    localparam lampi_t LampiVerde      = '{rosu: 1'b0, galben: 1'b0, verde: 1'b1};
    localparam lampi_t LampiGalben     = '{rosu: 1'b0, galben: 1'b1, verde: 1'b0};
    localparam lampi_t LampiStins      = '{rosu: 1'b0, galben: 1'b0, verde: 1'b0};

    // Default timings (seconds, except SecDefault which is clocks per second)
    localparam logic [23:0] SecDefault          = 24'd10000000;
    localparam int unsigned TVerdeMinDefault    = 10;
    localparam int unsigned TGalbenDefault      = 3;
    localparam int unsigned TRosuGalbenDefault  = 2;
    localparam int unsigned TTimeoutDefault     = 30;

    // Steady lamps per state; maintenance yellow blinking is layered on by the caller.
    function automatic lampi_t lampi_stare(input logic [2:0] st);
        lampi_t l;
        case (st)
            StInit:        l = LampiRosu;
            StRosuGalben:  l = LampiRosuGalben;
            StVerde:       l = LampiVerde;
            StGalben:      l = LampiGalben;
            StRosuStart:   l = LampiRosu;
            StRosuAstept:  l = LampiRosu;
            StIntretinere: l = LampiStins;
            default:       l = LampiRosu;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick generator.
// Free-running counter 0..SEC-1; tick_o is high while the counter is at SEC-1 and
// half_o while it is at SEC/2-1. Never realigned by the controller.
// Ports: clk_i clock, rst_ni async active-low reset, tick_o / half_o one-clock strobes.
module tick_gen
    import semafoare_pkg::*;
#(
    parameter logic [23:0] SEC = SecDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o,
    output logic half_o
);

    logic [23:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == SEC - 24'd1);
    assign half_o = (cnt_q == (SEC >> 1) - 24'd1);

    always_comb begin
        cnt_d = tick_o ? 24'd0 : cnt_q + 24'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/modul_masini.sv
// Vehicle-side traffic-light controller.
// Runs the car lamps, latches pedestrian requests, starts the crossing handshake with a
// one-clock Pietoni_start and holds red until Pietoni_stop. Offers blinking-yellow
// maintenance and a sticky watchdog fault if the pedestrian side never answers.
// Ports:
//   clk, reset (async active-low)
//   intretinere    maintenance request level (asynchronous)
//   buton_pietoni  pedestrian push-button (asynchronous)
//   Pietoni_stop   pedestrian side done, one-clock pulse
//   Pietoni_start  crossing request, one-clock pulse
//   Verde_masini_o / Galben_masini_o / Rosu_masini_o  car lamps (registered)
//   eroare_o       sticky watchdog fault, cleared only by reset
module modul_masini
    import semafoare_pkg::*;
#(
    parameter logic [23:0] SEC           = SecDefault,
    parameter int unsigned T_VERDE_MIN   = TVerdeMinDefault,
    parameter int unsigned T_GALBEN      = TGalbenDefault,
    parameter int unsigned T_ROSU_GALBEN = TRosuGalbenDefault,
    parameter int unsigned T_TIMEOUT     = TTimeoutDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic intretinere,
    input  logic buton_pietoni,
    input  logic Pietoni_stop,
    output logic Pietoni_start,
    output logic Verde_masini_o,
    output logic Galben_masini_o,
    output logic Rosu_masini_o,
    output logic eroare_o
);

    // Timed states leave on their Nth tick, i.e. when the count of earlier ticks is N-1.
    localparam logic [7:0] VerdeMin    = 8'(T_VERDE_MIN);
    localparam logic [7:0] GalbenLast  = 8'(T_GALBEN - 1);
    localparam logic [7:0] RgLast      = 8'(T_ROSU_GALBEN - 1);
    localparam logic [7:0] TimeoutLast = 8'(T_TIMEOUT - 1);

    logic       tick, half;
    logic       intr_sync1_q, intr_sync2_q;
    logic       btn_sync1_q, btn_sync2_q, btn_prev_q;
    logic       cerere_q, cerere_d;
    logic [2:0] state_q, state_d;
    logic [7:0] sec_cnt_q, sec_cnt_d;
    logic       rosu_q, rosu_d;
    logic       galben_q, galben_d;
    logic       verde_q, verde_d;
    logic       start_q, start_d;
    logic       eroare_q, eroare_d;
    logic       timeout;
    logic       btn_rise;
    lampi_t     lampi;

    tick_gen #(
        .SEC (SEC)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_ni (reset),
        .tick_o (tick),
        .half_o (half)
    );

    assign btn_rise = btn_sync2_q & ~btn_prev_q;

    // Next state
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            StInit: begin
                if (intr_sync2_q)  state_d = StIntretinere;
                else if (tick)     state_d = StRosuGalben;
            end
            StRosuGalben: begin
                if (intr_sync2_q)                     state_d = StIntretinere;
                else if (tick && sec_cnt_q >= RgLast) state_d = StVerde;
            end
            StVerde: begin
                if (intr_sync2_q)                            state_d = StIntretinere;
                else if (sec_cnt_q >= VerdeMin && cerere_q)  state_d = StGalben;
            end
            StGalben: begin
                if (intr_sync2_q)                         state_d = StIntretinere;
                else if (tick && sec_cnt_q >= GalbenLast) state_d = StRosuStart;
            end
            StRosuStart: begin
                state_d = StRosuAstept;
            end
            StRosuAstept: begin
                // Stop beats a coincident timeout; maintenance waits for the handshake.
                if (Pietoni_stop) begin
                    state_d = intr_sync2_q ? StIntretinere : StRosuGalben;
                end else if (tick && sec_cnt_q >= TimeoutLast) begin
                    state_d = StIntretinere;
                    timeout = 1'b1;
                end
            end
            StIntretinere: begin
                if (!intr_sync2_q && !eroare_q) state_d = StInit;
            end
            default: state_d = StInit;
        endcase
    end

    // State timer, request latch and fault
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        if (state_d != state_q) begin
            sec_cnt_d = 8'd0;
        end else if (tick && sec_cnt_q != 8'hFF) begin
            sec_cnt_d = sec_cnt_q + 8'd1;
        end

        cerere_d = cerere_q;
        if (state_q == StRosuStart)   cerere_d = 1'b0;
        if (btn_rise)                 cerere_d = 1'b1;
        if (state_q == StIntretinere) cerere_d = 1'b0;

        eroare_d = eroare_q | timeout;
    end

    // Registered outputs follow the next state so they line up with state_q.
    always_comb begin
        lampi    = lampi_stare(state_d);
        rosu_d   = lampi.rosu;
        verde_d  = lampi.verde;
        galben_d = lampi.galben;
        if (state_d == StIntretinere) begin
            if (state_q != StIntretinere) galben_d = 1'b1;
            else if (tick || half)        galben_d = ~galben_q;
            else                          galben_d = galben_q;
        end
        start_d = (state_d == StRosuStart);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr_sync1_q <= 1'b0;
            intr_sync2_q <= 1'b0;
            btn_sync1_q  <= 1'b0;
            btn_sync2_q  <= 1'b0;
            btn_prev_q   <= 1'b0;
            cerere_q     <= 1'b0;
            state_q      <= StInit;
            sec_cnt_q    <= 8'd0;
            rosu_q       <= 1'b1;
            galben_q     <= 1'b0;
            verde_q      <= 1'b0;
            start_q      <= 1'b0;
            eroare_q     <= 1'b0;
        end else begin
            intr_sync1_q <= intretinere;
            intr_sync2_q <= intr_sync1_q;
            btn_sync1_q  <= buton_pietoni;
            btn_sync2_q  <= btn_sync1_q;
            btn_prev_q   <= btn_sync2_q;
            cerere_q     <= cerere_d;
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            rosu_q       <= rosu_d;
            galben_q     <= galben_d;
            verde_q      <= verde_d;
            start_q      <= start_d;
            eroare_q     <= eroare_d;
        end
    end

    assign Rosu_masini_o   = rosu_q;
    assign Galben_masini_o = galben_q;
    assign Verde_masini_o  = verde_q;
    assign Pietoni_start   = start_q;
    assign eroare_o        = eroare_q;

endmodule

// File: tb/tb_modul_masini.sv
// Self-checking bench for modul_masini with SEC=10.
// Expected lamps are derived from elapsed cycle counts: ticks fall on cycles k with
// k % SEC == SEC-1 (cycle 0 is the first cycle after reset release), a timed phase ends
// on its Nth tick, and the blink toggles on every tick and half-tick.
module tb_modul_masini;

    localparam int S   = 10;
    localparam int TVM = 10;
    localparam int TG  = 3;
    localparam int TRG = 2;
    localparam int TTO = 30;

    localparam logic [2:0] L_RED = 3'b100;  // {R,Y,G}
    localparam logic [2:0] L_RY  = 3'b110;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_Y   = 3'b010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic intretinere = 1'b0;
    logic buton_pietoni = 1'b0;
    logic Pietoni_stop = 1'b0;
    logic Pietoni_start, Verde_masini_o, Galben_masini_o, Rosu_masini_o, eroare_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    modul_masini #(
        .SEC           (24'd10),
        .T_VERDE_MIN   (TVM),
        .T_GALBEN      (TG),
        .T_ROSU_GALBEN (TRG),
        .T_TIMEOUT     (TTO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .intretinere     (intretinere),
        .buton_pietoni   (buton_pietoni),
        .Pietoni_stop    (Pietoni_stop),
        .Pietoni_start   (Pietoni_start),
        .Verde_masini_o  (Verde_masini_o),
        .Galben_masini_o (Galben_masini_o),
        .Rosu_masini_o   (Rosu_masini_o),
        .eroare_o        (eroare_o)
    );

    // Cycle of the nth tick at or after cycle e.
    function automatic int nth_tick(input int e, input int n);
        return e + (S - 1 - (e % S)) + (n - 1) * S;
    endfunction

    // Maintenance yellow at cycle k for a blink phase entered at cycle e.
    function automatic logic blink_y(input int e, input int k);
        int c;
        c = 0;
        for (int t = e; t < k; t++) begin
            if (t % (S / 2) == S / 2 - 1) c++;
        end
        return (c % 2 == 0);
    endfunction

    function automatic logic [4:0] obs();
        return {Rosu_masini_o, Galben_masini_o, Verde_masini_o, Pietoni_start, eroare_o};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = obs();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed RYG_start_err=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic seg(input string tag, input int upto, input logic [2:0] l,
                       input logic st, input logic er);
        while (cyc <= upto) begin
            check(tag, {l, st, er});
            step();
        end
    endtask

    task automatic blink(input string tag, input int e, input int upto, input logic er);
        while (cyc <= upto) begin
            check(tag, {1'b0, blink_y(e, cyc), 1'b0, 1'b0, er});
            step();
        end
    endtask

    // Called just after a negedge sample; asserts reset mid-cycle and checks it acts at once.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        intretinere = 1'b0;
        buton_pietoni = 1'b0;
        Pietoni_stop = 1'b0;
        #1;
        check("reset_async", {L_RED, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    // From INIT entry at cycle i0 through ROSU_GALBEN; returns first VERDE cycle.
    task automatic from_init(input int i0, output int v);
        int r0;
        r0 = nth_tick(i0, 1) + 1;
        seg("init", r0 - 1, L_RED, 1'b0, 1'b0);
        v = nth_tick(r0, TRG) + 1;
        seg("rosu_galben", v - 1, L_RY, 1'b0, 1'b0);
    endtask

    task automatic press(input int p);
        int len;
        len = int'($urandom_range(1, 3));
        seg("verde_pre_press", p - 1, L_G, 1'b0, 1'b0);
        buton_pietoni = 1'b1;
        seg("verde_press", p + len - 1, L_G, 1'b0, 1'b0);
        buton_pietoni = 1'b0;
    endtask

    // Green held until min-green elapsed and request visible, then yellow; returns START cycle.
    task automatic serve(input int v, input int ready, output int s);
        int t10, c;
        t10 = nth_tick(v, TVM);
        c = (ready > t10 + 1) ? ready : t10 + 1;
        seg("verde_hold", c, L_G, 1'b0, 1'b0);
        s = nth_tick(c + 1, TG) + 1;
        seg("galben", s - 1, L_Y, 1'b0, 1'b0);
    endtask

    initial begin
        int v0, v1, v2, p, p2, s0, s1, a0, a1, tmo, sd, pa, d, k, q, e, mi;

        // 1: idle green, stray stop ignored, no start
        do_reset();
        from_init(0, v0);
        k = v0 + int'($urandom_range(5, 400));
        seg("verde_idle", k - 1, L_G, 1'b0, 1'b0);
        Pietoni_stop = 1'b1;
        seg("verde_stray_stop", k, L_G, 1'b0, 1'b0);
        Pietoni_stop = 1'b0;
        seg("verde_idle", v0 + 500, L_G, 1'b0, 1'b0);

        // 2: press at sec_cnt=3, handshake, press during red served next round
        do_reset();
        from_init(0, v0);
        p = int'($urandom_range(nth_tick(v0, 3) + 1, nth_tick(v0, 4)));
        press(p);
        serve(v0, p + 3, s0);
        seg("start", s0, L_RED, 1'b1, 1'b0);
        a0 = s0 + 1;
        d = int'($urandom_range(20, 250));
        sd = s0 + d;
        pa = a0 + int'($urandom_range(0, d - 12));
        seg("astept", pa - 1, L_RED, 1'b0, 1'b0);
        buton_pietoni = 1'b1;
        seg("astept_press", pa, L_RED, 1'b0, 1'b0);
        buton_pietoni = 1'b0;
        seg("astept", sd - 1, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b1;
        seg("astept_stop", sd, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b0;
        v1 = nth_tick(sd + 1, TRG) + 1;
        seg("rg_after_stop", v1 - 1, L_RY, 1'b0, 1'b0);
        serve(v1, pa + 3, s1);
        seg("start_again", s1, L_RED, 1'b1, 1'b0);
        seg("astept_again", s1 + 5, L_RED, 1'b0, 1'b0);

        // 3: watchdog timeout, sticky fault
        do_reset();
        from_init(0, v0);
        p = v0 + int'($urandom_range(0, 60));
        press(p);
        serve(v0, p + 3, s0);
        seg("start", s0, L_RED, 1'b1, 1'b0);
        a0 = s0 + 1;
        tmo = nth_tick(a0, TTO);
        seg("astept_wait", tmo, L_RED, 1'b0, 1'b0);
        blink("fault_blink", tmo + 1, tmo + 40, 1'b1);
        intretinere = 1'b1;
        blink("fault_maint_on", tmo + 1, tmo + 60, 1'b1);
        intretinere = 1'b0;
        blink("fault_maint_off", tmo + 1, tmo + 100, 1'b1);

        // 4: maintenance from green, pending press discarded
        do_reset();
        from_init(0, v0);
        p = v0 + int'($urandom_range(0, 30));
        press(p);
        mi = cyc + int'($urandom_range(0, 20));
        seg("verde_pre_maint", mi - 1, L_G, 1'b0, 1'b0);
        intretinere = 1'b1;
        e = mi + 3;
        seg("verde_maint_sync", e - 1, L_G, 1'b0, 1'b0);
        blink("maint_blink", e, e + int'($urandom_range(20, 60)), 1'b0);
        intretinere = 1'b0;
        q = cyc;
        blink("maint_exit_sync", e, q + 2, 1'b0);
        from_init(q + 3, v1);
        seg("pending_discarded", v1 + 200, L_G, 1'b0, 1'b0);

        // 5: maintenance deferred by handshake; stop coincident with timeout tick
        do_reset();
        from_init(0, v0);
        p = v0 + int'($urandom_range(0, 40));
        press(p);
        serve(v0, p + 3, s0);
        seg("start", s0, L_RED, 1'b1, 1'b0);
        a0 = s0 + 1;
        seg("astept", a0 + 1, L_RED, 1'b0, 1'b0);
        intretinere = 1'b1;
        sd = a0 + int'($urandom_range(10, 200));
        seg("astept_maint_deferred", sd - 1, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b1;
        seg("astept_stop", sd, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b0;
        blink("maint_after_hs", sd + 1, sd + 30, 1'b0);
        intretinere = 1'b0;
        q = cyc;
        blink("maint_exit_sync", sd + 1, q + 2, 1'b0);
        from_init(q + 3, v1);
        p2 = v1 + int'($urandom_range(0, 40));
        press(p2);
        serve(v1, p2 + 3, s1);
        seg("start2", s1, L_RED, 1'b1, 1'b0);
        a1 = s1 + 1;
        tmo = nth_tick(a1, TTO);
        seg("astept2", tmo - 1, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b1;
        seg("stop_at_timeout", tmo, L_RED, 1'b0, 1'b0);
        Pietoni_stop = 1'b0;
        v2 = nth_tick(tmo + 1, TRG) + 1;
        seg("rg_no_fault", v2 - 1, L_RY, 1'b0, 1'b0);
        seg("verde_no_fault", v2 + 20, L_G, 1'b0, 1'b0);

        // 6: reset asserted during ROSU_START
        do_reset();
        from_init(0, v0);
        p = v0 + int'($urandom_range(0, 40));
        press(p);
        serve(v0, p + 3, s0);
        check("start_pre_reset", {L_RED, 1'b1, 1'b0});
        do_reset();
        from_init(0, v0);
        seg("verde_after_reset", v0 + 20, L_G, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
